interfaz_vga: RTL and testbench
===============================

# interfaz_vga

VGA text-overlay block that latches eight bytes from the RTC controller and shows them as BCD digits on a 640×480 screen. It contains its own sync generator and a glyph ROM. It sits between the RTC read/write sequencer (which supplies `datoRTC`, `inicioSecuencia`, `cursor` and the timer flags) and the board VGA connector.

## Interface
Parameters: none. System clock is fixed at 100 MHz; pixel rate is 25 MHz.
- `clk` in 1: 100 MHz system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `inicioSecuencia` in 1: a high level starts and frames an 8-byte load burst.
- `datoRTC` in 8: RTC byte, packed BCD (tens in [7:4], units in [3:0]).
- `temporizador` in 1: 1 enables the timer row.
- `temporizadorFin` in 1: 1 means the timer has expired; the timer row turns red.
- `cursor` in 3: index 0–7 of the field being edited; that field is highlighted.
- `rgb` out 12: pixel colour, RRRRGGGGBBBB.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `font_bit` out 1: glyph pixel at the current position (1 = ink).
- `video_on` out 1: high inside the 640×480 visible area.

## Operation
- **Pixel tick:** a 2-bit divider pulses `tick` for one clk out of every 4. Pixel counters x (0–799) and y (0–524) advance only on `tick`.
- **Horizontal timing:** 640 visible, 16 front porch, 96 sync, 48 back porch. `hsync` = 0 for x in 656..751.
- **Vertical timing:** 480 visible, 10 front porch, 2 sync, 33 back porch. `vsync` = 0 for y in 490..491.
- **Visible area:** `video_on` = (x<640) && (y<480). `rgb` = 12'h000 whenever `video_on` = 0.
- **Load sequencer:** a 3-bit index plus a busy flag.
  - A rising edge of `inicioSecuencia` (low→high, detected with a registered copy) arms the sequencer.
  - The byte is captured on each of the next 8 clk edges, in order: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year, 6 timer sec, 7 timer min.
  - After index 7, busy clears.
  - `inicioSecuencia` staying high after the burst is ignored; only a new rising edge starts another burst.
  - Captured bytes hold until the next burst.
- **Text grid:** 80×30 cells of 8×16 pixels. Cell column = x[9:3], cell row = y[8:4].
  - Row 10, columns 36–43: "DD/MM/YY" (bytes 3, 4, 5).
  - Row 14, columns 36–43: "HH:MM:SS" (bytes 2, 1, 0).
  - Row 18, columns 37–41: "MM:SS" (bytes 7, 6). Drawn only when `temporizador` = 1.
  - Every other cell is blank.
- **Glyph ROM:** combinational, 8×16 glyphs for digits 0–9, ':' and '/', and blank. Index = glyph code and y[3:0]; bit = 7 − x[2:0].
  - A nibble above 9 displays as blank.
- **Colour priority** (applies to ink pixels only; background is always 12'h000):
  1. Field whose index equals `cursor`: 12'hFF0.
  2. Timer row with `temporizadorFin` = 1: 12'hF00.
  3. Otherwise: 12'hFFF.
- **`font_bit`:** the glyph bit for the current pixel; 0 in blank cells and outside the visible area.

## Timing
- `rgb`, `hsync`, `vsync`, `video_on` and `font_bit` are registered. They reflect the counter values of the previous clk and stay mutually aligned, so each pixel is held for 4 clk.
- One line = 800 pixels = 32 µs. One frame = 525 lines = 16.8 ms. Visible area ends 15.36 ms after the frame starts.
- **Load latency:** `inicioSecuencia` seen high at edge k ⇒ bytes captured at edges k+1 … k+8. A newly captured byte affects `rgb` no later than the next pixel drawn in that cell.
- **Reset (async):**
  - Clears the divider, x, y and the load sequencer.
  - Outputs go to `hsync` = 1, `vsync` = 1, `video_on` = 0, `rgb` = 0, `font_bit` = 0.
  - After release, scanning restarts at (0,0).
  - Captured data registers are NOT cleared by reset; power-up value is 0.
- **Reset mid-burst:** the burst is aborted; bytes already captured are kept and the remaining ones keep their old values.
- **Counter wrap:** x wraps 799→0 while incrementing y. y wraps 524→0.

## Test plan
- **Sync after reset:** release reset, run one frame. Expect `hsync` low for 96×4 clk every 3200 clk, `vsync` low for 2 lines every 16.8 ms, and `video_on` high for exactly 640×480 pixels.
- **Load burst:** raise `inicioSecuencia`, then drive 8'd24, 4, 3, 23, 12, 21, 5, 6 on successive clk. Expect the time row to read "03:04:18" and the date row "17/0C→blank/15", i.e. digit glyphs per BCD nibble, with the nibble C shown blank.
- **Reset keeps data:** pulse reset for one clk after the burst. Expect the same digits in the next frame and the scan to restart at (0,0).
- **Cursor highlight:** `cursor` = 0. Expect the seconds digits' ink = 12'hFF0 and all other ink = 12'hFFF.
- **Timer row:** `temporizador` = 0 ⇒ row 18 blank. `temporizador` = 1, `temporizadorFin` = 1, `cursor` = 2 ⇒ row 18 shows "06:05" with ink = 12'hF00.
- **Blanking:** in the porches, `rgb` = 0, `font_bit` = 0 and `video_on` = 0.

Source files
------------

// File: rtl/interfaz_vga.sv
// 640x480 VGA text overlay: 25 MHz sync generator from a 100 MHz clock, 8-byte RTC
// capture sequencer, and BCD digit rendering through a combinational glyph ROM.
module interfaz_vga (
    input  logic        clk,
    input  logic        reset,
    input  logic        inicioSecuencia,
    input  logic [7:0]  datoRTC,
    input  logic        temporizador,
    input  logic        temporizadorFin,
    input  logic [2:0]  cursor,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        font_bit,
    output logic        video_on
);

    typedef enum logic {SEQ_IDLE, SEQ_LOAD} seq_state_t;

    localparam logic [3:0] G_COLON = 4'd10;
    localparam logic [3:0] G_SLASH = 4'd11;
    localparam logic [3:0] G_BLANK = 4'd15;

    logic [1:0]  div_q, div_d;
    logic        tick;
    logic [9:0]  x_q, x_d, y_q, y_d;
    seq_state_t  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        inicio_q, inicio_d;
    logic        wr_en;
    logic [7:0]  dat_q [8];

    logic [6:0]  col;
    logic [4:0]  row;
    logic [2:0]  pos;
    logic        in_field, hi_nib, tmr_row;
    logic [2:0]  fld;
    logic [7:0]  fld_byte;
    logic [3:0]  nib, code;
    logic [7:0]  glyph_bits;
    logic        vis, ink;
    logic [11:0] colour;

    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        font_bit_q, font_bit_d, video_on_q, video_on_d;

    // 8x16 glyphs, row 0 in the top byte of each bitmap
    function automatic logic [7:0] glyph_rom(input logic [3:0] g, input logic [3:0] r);
        logic [127:0] bmp;
        case (g)
            4'd0:    bmp = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            4'd1:    bmp = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            4'd2:    bmp = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            4'd3:    bmp = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            4'd4:    bmp = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            4'd5:    bmp = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            4'd6:    bmp = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            4'd7:    bmp = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            4'd8:    bmp = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            4'd9:    bmp = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            G_COLON: bmp = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
            G_SLASH: bmp = 128'h0000_0000_0206_0C18_3060_C080_0000_0000;
            default: bmp = '0;
        endcase
        return bmp[{~r, 3'b111} -: 8];
    endfunction

    always_comb begin
        div_d = div_q + 2'd1;
        tick  = (div_q == 2'd3);
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == 10'd799) begin
                x_d = '0;
                y_d = (y_q == 10'd524) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        inicio_d = inicioSecuencia;
        wr_en    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (inicioSecuencia && !inicio_q) begin
                    state_d = SEQ_LOAD;
                    idx_d   = '0;
                end
            end
            SEQ_LOAD: begin
                wr_en = 1'b1;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_comb begin
        col      = x_q[9:3];
        row      = y_q[8:4];
        pos      = '0;
        in_field = 1'b0;
        hi_nib   = 1'b0;
        tmr_row  = 1'b0;
        fld      = '0;
        code     = G_BLANK;
        // Date/time rows share one 8-cell layout; pos 2 and 5 are the separators
        if ((row == 5'd10 || row == 5'd14) && col >= 7'd36 && col <= 7'd43) begin
            pos = col[2:0] - 3'd4;
            case (pos)
                3'd2, 3'd5: code = (row == 5'd10) ? G_SLASH : G_COLON;
                default: begin
                    in_field = 1'b1;
                    hi_nib   = (pos == 3'd0) || (pos == 3'd3) || (pos == 3'd6);
                    if (row == 5'd10) fld = (pos < 3'd2) ? 3'd3 : (pos < 3'd5) ? 3'd4 : 3'd5;
                    else              fld = (pos < 3'd2) ? 3'd2 : (pos < 3'd5) ? 3'd1 : 3'd0;
                end
            endcase
        end else if (row == 5'd18 && temporizador && col >= 7'd37 && col <= 7'd41) begin
            tmr_row = 1'b1;
            pos     = col[2:0] - 3'd5;
            if (pos == 3'd2) begin
                code = G_COLON;
            end else begin
                in_field = 1'b1;
                hi_nib   = (pos == 3'd0) || (pos == 3'd3);
                fld      = (pos < 3'd2) ? 3'd7 : 3'd6;
            end
        end
        fld_byte = dat_q[fld];
        nib      = hi_nib ? fld_byte[7:4] : fld_byte[3:0];
        if (in_field) code = (nib > 4'd9) ? G_BLANK : nib;
        glyph_bits = glyph_rom(code, y_q[3:0]);
        vis = (x_q < 10'd640) && (y_q < 10'd480);
        ink = vis && glyph_bits[~x_q[2:0]];
        if (in_field && fld == cursor)      colour = 12'hFF0;
        else if (tmr_row && temporizadorFin) colour = 12'hF00;
        else                                 colour = 12'hFFF;
        rgb_d      = ink ? colour : '0;
        font_bit_d = ink;
        video_on_d = vis;
        hsync_d    = !((x_q >= 10'd656) && (x_q <= 10'd751));
        vsync_d    = !((y_q >= 10'd490) && (y_q <= 10'd491));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            state_q    <= SEQ_IDLE;
            idx_q      <= '0;
            inicio_q   <= 1'b0;
            rgb_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            font_bit_q <= 1'b0;
            video_on_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            inicio_q   <= inicio_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            font_bit_q <= font_bit_d;
            video_on_q <= video_on_d;
        end
    end

    // Captured bytes deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) dat_q[idx_q] <= datoRTC;
    end

    assign rgb      = rgb_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign font_bit = font_bit_q;
    assign video_on = video_on_q;

endmodule

// File: tb/tb_interfaz_vga.sv
// Directed bench for interfaz_vga: per-pixel scoreboard of sync, blanking and text rendering.
module tb_interfaz_vga;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicioSecuencia;
    logic [7:0]  datoRTC;
    logic        temporizador;
    logic        temporizadorFin;
    logic [2:0]  cursor;
    logic [11:0] rgb;
    logic        hsync, vsync, font_bit, video_on;

    always #5 clk = ~clk;

    interfaz_vga dut (
        .clk             (clk),
        .reset           (reset),
        .inicioSecuencia (inicioSecuencia),
        .datoRTC         (datoRTC),
        .temporizador    (temporizador),
        .temporizadorFin (temporizadorFin),
        .cursor          (cursor),
        .rgb             (rgb),
        .hsync           (hsync),
        .vsync           (vsync),
        .font_bit        (font_bit),
        .video_on        (video_on)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        fb;
    } pix_t;

    typedef struct {
        pix_t  p;
        int    x;
        int    y;
        string tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mb [8];
    logic [9:0]  dep_x, dep_y;
    logic [7:0]  vals  [8] = '{8'd24, 8'd4, 8'd3, 8'd23, 8'd12, 8'd21, 8'd5, 8'd6};
    logic [7:0]  vals2 [3] = '{8'h59, 8'hAB, 8'h22};
    int          lay_dt [8] = '{3, 3, -1, 4, 4, -1, 5, 5};
    int          lay_tm [8] = '{2, 2, -1, 1, 1, -1, 0, 0};
    int          lay_tr [5] = '{7, 7, -1, 6, 6};

    function automatic logic [7:0] font_row(input byte ch, input int r);
        logic [127:0] g;
        case (ch)
            "0": g = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            "1": g = 128'h00001838781818181818187E00000000;
            "2": g = 128'h00007CC6060C183060C0C6FE00000000;
            "3": g = 128'h00007CC606063C060606C67C00000000;
            "4": g = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            "5": g = 128'h0000FEC0C0C0FC060606C67C00000000;
            "6": g = 128'h00003860C0C0FCC6C6C6C67C00000000;
            "7": g = 128'h0000FEC606060C183030303000000000;
            "8": g = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            "9": g = 128'h00007CC6C6C67E0606060C7800000000;
            ":": g = 128'h00000000181800000018180000000000;
            "/": g = 128'h0000000002060C183060C08000000000;
            default: g = '0;
        endcase
        return g[127 - 8*r -: 8];
    endfunction

    function automatic byte dch(input logic [3:0] n);
        if (n <= 4'd9) return byte'(8'd48 + {4'd0, n});
        return " ";
    endfunction

    function automatic pix_t model(input int x, input int y);
        pix_t       p;
        int         col, row, i, f;
        bit         trow, vis, ink;
        byte        ch;
        logic [7:0] gb;
        col  = x / 8;
        row  = (y / 16) % 32;
        f    = -1;
        trow = 1'b0;
        ch   = " ";
        if ((row == 10 || row == 14) && col >= 36 && col <= 43) begin
            i = col - 36;
            f = (row == 10) ? lay_dt[i] : lay_tm[i];
            if (f < 0) ch = (row == 10) ? "/" : ":";
            else       ch = dch((i % 3 == 0) ? mb[f][7:4] : mb[f][3:0]);
        end else if (row == 18 && temporizador && col >= 37 && col <= 41) begin
            i    = col - 37;
            trow = 1'b1;
            f    = lay_tr[i];
            if (f < 0) ch = ":";
            else       ch = dch((i % 3 == 0) ? mb[f][7:4] : mb[f][3:0]);
        end
        gb   = font_row(ch, y % 16);
        vis  = (x < 640) && (y < 480);
        ink  = vis && gb[7 - (x % 8)];
        p.fb = ink;
        p.vo = vis;
        p.hs = !(x >= 656 && x <= 751);
        p.vs = !(y >= 490 && y <= 491);
        if (!ink)                                 p.rgb = 12'h000;
        else if (f >= 0 && f == int'(cursor))     p.rgb = 12'hFF0;
        else if (trow && temporizadorFin)         p.rgb = 12'hF00;
        else                                      p.rgb = 12'hFFF;
        return p;
    endfunction

    task automatic compare_head();
        exp_t e;
        pix_t obs;
        obs = {rgb, hsync, vsync, video_on, font_bit};
        e   = sb.pop_front();
        checks++;
        assert (obs === e.p) else begin
            errors++;
            $error("FAIL %s (%0d,%0d): got rgb=%h hs=%b vs=%b vo=%b fb=%b, expected rgb=%h hs=%b vs=%b vo=%b fb=%b",
                   e.tag, e.x, e.y, obs.rgb, obs.hs, obs.vs, obs.vo, obs.fb,
                   e.p.rgb, e.p.hs, e.p.vs, e.p.vo, e.p.fb);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t e;
        e.p   = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        e.x   = -1;
        e.y   = -1;
        e.tag = tag;
        sb.push_back(e);
        #1;
        compare_head();
    endtask

    // Moves the scan position without waiting a whole frame; divider phase set to 0
    task automatic jump_to(input int x, input int y);
        @(negedge clk);
        dep_x = 10'(x);
        dep_y = 10'(y);
        force dut.div_q = 2'd0;
        force dut.x_q   = dep_x;
        force dut.y_q   = dep_y;
        #1;
        release dut.div_q;
        release dut.x_q;
        release dut.y_q;
    endtask

    task automatic scan(input string tag, input int x0, input int y0, input int n, input bit jump);
        exp_t e;
        int   x, y;
        if (jump) jump_to(x0, y0);
        x = x0;
        y = y0;
        for (int k = 0; k < n; k++) begin
            e.p   = model(x, y);
            e.x   = x;
            e.y   = y;
            e.tag = tag;
            sb.push_back(e);
            @(posedge clk);
            #1;
            compare_head();
            repeat (3) @(posedge clk);
            x++;
            if (x == 800) begin
                x = 0;
                y = (y == 524) ? 0 : y + 1;
            end
        end
    endtask

    task automatic text_row(input string tag, input int r);
        for (int gy = 1; gy < 13; gy++) scan(tag, 280, r * 16 + gy, 80, 1'b1);
    endtask

    initial begin
        reset           = 1'b1;
        inicioSecuencia = 1'b0;
        datoRTC         = 8'h00;
        temporizador    = 1'b0;
        temporizadorFin = 1'b0;
        cursor          = 3'd0;
        for (int i = 0; i < 8; i++) mb[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        reset = 1'b0;
        scan("sync_from_reset", 0, 0, 1700, 1'b0);
        scan("vsync_start", 700, 489, 300, 1'b1);
        scan("vsync_end", 790, 491, 20, 1'b1);
        scan("frame_wrap", 795, 524, 10, 1'b1);
        scan("visible_right", 630, 479, 20, 1'b1);
        scan("visible_bottom", 795, 479, 10, 1'b1);

        @(negedge clk);
        inicioSecuencia = 1'b1;
        datoRTC         = 8'hEE;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            datoRTC = vals[i];
            mb[i]   = vals[i];
            @(posedge clk);
        end
        @(negedge clk);
        datoRTC = 8'h99;

        cursor = 3'd0;
        text_row("date", 10);
        text_row("time_cur0", 14);
        text_row("timer_off", 18);

        @(negedge clk);
        reset           = 1'b1;
        inicioSecuencia = 1'b0;
        check_reset_outputs("reset_pulse");
        @(negedge clk);
        reset = 1'b0;
        scan("restart", 0, 0, 8, 1'b0);
        cursor = 3'd3;
        text_row("date_cur3", 10);
        text_row("time_cur3", 14);

        temporizador    = 1'b1;
        temporizadorFin = 1'b1;
        cursor          = 3'd2;
        text_row("timer_fin", 18);
        text_row("time_cur2", 14);
        cursor = 3'd6;
        text_row("timer_cur6", 18);
        temporizadorFin = 1'b0;
        cursor          = 3'd7;
        text_row("timer_cur7", 18);

        @(negedge clk);
        inicioSecuencia = 1'b1;
        datoRTC         = 8'hEE;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            datoRTC = vals2[i];
            mb[i]   = vals2[i];
            @(posedge clk);
        end
        @(negedge clk);
        reset           = 1'b1;
        datoRTC         = 8'h77;
        inicioSecuencia = 1'b0;
        check_reset_outputs("reset_midburst");
        @(negedge clk);
        reset = 1'b0;
        scan("restart2", 0, 0, 4, 1'b0);
        cursor          = 3'd0;
        temporizadorFin = 1'b1;
        text_row("time_partial", 14);
        text_row("date_kept", 10);
        text_row("timer_kept", 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
